rle_block_sequencer: RTL and testbench



---
 rtl/rle_pkg.sv | 16 +
 rtl/rle_block_sequencer_if.sv | 59 +++++
 rtl/rle_rr_arbiter.sv | 36 +++
 rtl/rle_block_sequencer.sv | 144 ++++++++++++++
 tb/tb_rle_block_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE block sequencer.
// Row count per block, FSM states, default row width, perf width.
package rle_pkg;

  localparam int ROWS_PER_BLOCK = 8;
  localparam int ROW_CNT_W      = $clog2(ROWS_PER_BLOCK);
  localparam int ROW_W_DEF      = 64;
  localparam int PERF_W         = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT
  } state_t;

endpackage

// File: rtl/rle_block_sequencer_if.sv
// Bus bundle between block sources, the sequencer and the RLE core.
// slave: sequencer side; master: environment side.
// RLE_SEQ_PERF_EN adds perf_blk_cnt / perf_stall_cnt.
interface rle_block_sequencer_if
  import rle_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ROW_W   = ROW_W_DEF,
  parameter int TAG_W   = 2
);

  logic                     cfg_enable;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*ROW_W-1:0] req_row;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rle_ready;
  logic                     rle_done;
  logic                     rle_row_valid;
  logic [ROW_W-1:0]         rle_row;
  logic                     rle_sob;
  logic                     rle_eob;
  logic [TAG_W-1:0]         rle_tag;
  logic                     busy;
`ifdef RLE_SEQ_PERF_EN
  logic [NUM_REQ*PERF_W-1:0] perf_blk_cnt;
  logic [PERF_W-1:0]         perf_stall_cnt;

  modport slave (
    input  cfg_enable, req_valid, req_row,
    input  rle_ready, rle_done,
    output req_ready, rle_row_valid, rle_row,
    output rle_sob, rle_eob, rle_tag, busy,
    output perf_blk_cnt, perf_stall_cnt
  );

  modport master (
    output cfg_enable, req_valid, req_row,
    output rle_ready, rle_done,
    input  req_ready, rle_row_valid, rle_row,
    input  rle_sob, rle_eob, rle_tag, busy,
    input  perf_blk_cnt, perf_stall_cnt
  );
`else
  modport slave (
    input  cfg_enable, req_valid, req_row,
    input  rle_ready, rle_done,
    output req_ready, rle_row_valid, rle_row,
    output rle_sob, rle_eob, rle_tag, busy
  );

  modport master (
    output cfg_enable, req_valid, req_row,
    output rle_ready, rle_done,
    input  req_ready, rle_row_valid, rle_row,
    input  rle_sob, rle_eob, rle_tag, busy
  );
`endif

endinterface

// File: rtl/rle_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Ports: req, ptr in; grant index and any_req out.
module rle_rr_arbiter
  import rle_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [TAG_W-1:0]   grant,
  output logic               any_req
);

  logic [TAG_W:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (TAG_W+1)'(k);
      // one conditional subtract is enough: ptr < NUM_REQ
      if (idx >= (TAG_W+1)'(NUM_REQ))
        idx = idx - (TAG_W+1)'(NUM_REQ);
      if (!found && req[idx[TAG_W-1:0]]) begin
        grant = idx[TAG_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rle_block_sequencer.sv
// Round-robin block sequencer feeding 8-row blocks to one RLE core.
// Ports: clk, reset (sync, active-high), bus (slave modport).
// Macro RLE_SEQ_PERF_EN adds per-source block and stall counters.
module rle_block_sequencer
  import rle_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ROW_W   = ROW_W_DEF,
  parameter int TAG_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  rle_block_sequencer_if.slave bus
);

  state_t                 state;
  state_t                 state_n;
  logic [TAG_W-1:0]       grant;
  logic [TAG_W-1:0]       ptr;
  logic [TAG_W-1:0]       arb_grant;
  logic                   any_req;
  logic [ROW_CNT_W-1:0]   row_cnt;
  logic                   is_last;
  logic                   hs;
  logic                   take;
  logic [ROW_W-1:0]       row_sel;
  logic [NUM_REQ-1:0]     ready_c;

  logic                   rv_q;
  logic [ROW_W-1:0]       row_q;
  logic                   sob_q;
  logic                   eob_q;
  logic [TAG_W-1:0]       tag_q;

  rle_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  always_comb begin
    row_sel = '0;
    ready_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == TAG_W'(i)) begin
        row_sel = bus.req_row[i*ROW_W +: ROW_W];
        if (state == STREAM)
          ready_c[i] = 1'b1;
      end
    end
  end

  assign hs      = |(bus.req_valid & ready_c);
  assign is_last = row_cnt == ROW_CNT_W'(ROWS_PER_BLOCK-1);
  assign take    = (state == IDLE) && (state_n == STREAM);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.cfg_enable && bus.rle_ready && any_req)
          state_n = STREAM;
      end
      STREAM: begin
        if (hs && is_last)
          state_n = WAIT;
      end
      WAIT: begin
        if (bus.rle_done)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      row_cnt <= '0;
      rv_q    <= 1'b0;
      row_q   <= '0;
      sob_q   <= 1'b0;
      eob_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        grant <= arb_grant;
        if (arb_grant == TAG_W'(NUM_REQ-1))
          ptr <= '0;
        else
          ptr <= arb_grant + TAG_W'(1);
      end
      rv_q  <= hs;
      sob_q <= hs && (row_cnt == '0);
      eob_q <= hs && is_last;
      if (hs) begin
        row_cnt <= is_last ? '0 : row_cnt + ROW_CNT_W'(1);
        row_q   <= row_sel;
        tag_q   <= grant;
      end
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.busy          = state != IDLE;
  assign bus.rle_row_valid = rv_q;
  assign bus.rle_row       = row_q;
  assign bus.rle_sob       = sob_q;
  assign bus.rle_eob       = eob_q;
  assign bus.rle_tag       = tag_q;

`ifdef RLE_SEQ_PERF_EN
  logic [NUM_REQ*PERF_W-1:0] blk_cnt;
  logic [PERF_W-1:0]         stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == WAIT && bus.rle_done) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant == TAG_W'(i))
            blk_cnt[i*PERF_W +: PERF_W] <=
              blk_cnt[i*PERF_W +: PERF_W] + PERF_W'(1);
        end
      end
      if (state == STREAM && !hs && stall_cnt != '1)
        stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign bus.perf_blk_cnt   = blk_cnt;
  assign bus.perf_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_rle_block_sequencer.sv
// Directed + random-data bench for rle_block_sequencer.
// Per-source row queues model the expected stream.
module tb_rle_block_sequencer;
  import rle_pkg::*;

  localparam int NR = 3;
  localparam int RW = 64;
  localparam int TW = 2;

  typedef logic [RW-1:0] row_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rle_block_sequencer_if #(
    .NUM_REQ (NR),
    .ROW_W   (RW),
    .TAG_W   (TW)
  ) bus ();

  rle_block_sequencer #(
    .NUM_REQ (NR),
    .ROW_W   (RW),
    .TAG_W   (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  row_t sq [NR][$];
  row_t eq [NR][$];
  int   tag_q [$];

  int   oidx      = 0;
  int   cur_tag   = 0;
  int   done_dly  = 2;
  int   done_cnt  = 0;
  int   gap_req   = -1;
  int   gap_at    = 0;
  int   gap_len   = 0;
  int   gap_left  = 0;
  int   popped [NR];
  int   blk [NR];
  int   bub       = 0;
  int   low_run   = 0;
  bit   waiting   = 0;
  bit   stray     = 0;
  bit   runchk    = 0;
  bit   seen_busy = 0;
  row_t last_row  = '0;
  int   last_tag  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_row(int r, row_t v);
    sq[r].push_back(v);
    eq[r].push_back(v);
  endtask

  task automatic queue_rand(int r);
    for (int k = 0; k < ROWS_PER_BLOCK; k++)
      push_row(r, {$urandom, $urandom});
  endtask

  task automatic cycle();
    logic [NR-1:0] acc;
    logic          done_smp;
    logic          rst_smp;
    row_t          er;
    // drive
    bus.rle_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.rle_done = 1'b1;
    end
    if (stray) begin
      bus.rle_done = 1'b1;
      stray = 0;
    end
    for (int i = 0; i < NR; i++) begin
      bit gap;
      gap = (i == gap_req) && (gap_left > 0);
      bus.req_valid[i] = (sq[i].size() > 0) && !gap;
      bus.req_row[i*RW +: RW] = bus.req_valid[i] ? sq[i][0] : '0;
    end
    if (gap_left > 0) gap_left--;
    // sample
    @(negedge clk);
    acc      = bus.req_valid & bus.req_ready;
    done_smp = bus.rle_done;
    rst_smp  = reset;
    @(posedge clk);
    #1;
    // source bookkeeping
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && !rst_smp) begin
        if (sq[i].size() > 0) sq[i].delete(0);
        popped[i]++;
        if (i == gap_req && popped[i] == gap_at)
          gap_left = gap_len;
      end
    end
    // output checks
    if (rst_smp) begin
      chk("rst_valid", 64'(bus.rle_row_valid), 64'(0));
      chk("rst_row",   64'(bus.rle_row),       64'(0));
      chk("rst_sob",   64'(bus.rle_sob),       64'(0));
      chk("rst_eob",   64'(bus.rle_eob),       64'(0));
      chk("rst_tag",   64'(bus.rle_tag),       64'(0));
      chk("rst_busy",  64'(bus.busy),          64'(0));
      chk("rst_ready", 64'(bus.req_ready),     64'(0));
`ifdef RLE_SEQ_PERF_EN
      chk("rst_pblk",   64'(bus.perf_blk_cnt),   64'(0));
      chk("rst_pstall", 64'(bus.perf_stall_cnt), 64'(0));
`endif
    end else if (bus.rle_row_valid) begin
      if (oidx == 0) begin
        if (tag_q.size() > 0) cur_tag = tag_q.pop_front();
        else cur_tag = -1;
      end
      chk("tag", 64'(bus.rle_tag), 64'(cur_tag));
      if (cur_tag < 0) cur_tag = 0;
      if (eq[cur_tag].size() > 0) er = eq[cur_tag].pop_front();
      else er = 'x;
      chk("row", bus.rle_row, er);
      chk("sob", 64'(bus.rle_sob), 64'(oidx == 0));
      chk("eob", 64'(bus.rle_eob), 64'(oidx == ROWS_PER_BLOCK-1));
      last_row = er;
      last_tag = cur_tag;
      if (oidx == ROWS_PER_BLOCK-1) begin
        oidx = 0;
        waiting = 1;
        done_cnt = done_dly;
      end else begin
        oidx++;
      end
    end else begin
      chk("idle_sob", 64'(bus.rle_sob), 64'(0));
      chk("idle_eob", 64'(bus.rle_eob), 64'(0));
      chk("hold_row", bus.rle_row, last_row);
      chk("hold_tag", 64'(bus.rle_tag), 64'(last_tag));
      if (oidx > 0) bub++;
    end
    if (!rst_smp) begin
      if (done_smp && waiting) begin
        chk("done_idle", 64'(bus.busy), 64'(0));
        waiting = 0;
        blk[cur_tag]++;
      end else if (waiting) begin
        chk("wait_busy", 64'(bus.busy), 64'(1));
      end
    end
    if (!bus.busy) begin
      low_run++;
    end else begin
      if (runchk && seen_busy && low_run > 0)
        chk("idle_gap", 64'(low_run), 64'(1));
      low_run = 0;
      seen_busy = 1;
    end
  endtask

  function automatic bit drained();
    bit d;
    d = (tag_q.size() == 0) && (oidx == 0) && !waiting;
    d = d && (done_cnt == 0) && !bus.busy;
    for (int i = 0; i < NR; i++)
      if (sq[i].size() > 0) d = 0;
    return d;
  endfunction

  task automatic run_idle(string tag, int maxc);
    int n = 0;
    while (!drained() && n < maxc) begin
      cycle();
      n++;
    end
    chk(tag, 64'(drained()), 64'(1));
  endtask

  task automatic run_until_left(int left, int maxc);
    int n = 0;
    bit ok = 0;
    while (!ok && n < maxc) begin
      cycle();
      n++;
      ok = (tag_q.size() == left) && (oidx == 0) && !waiting;
      ok = ok && (done_cnt == 0) && !bus.busy;
    end
    chk("blk_end", 64'(ok), 64'(1));
  endtask

  task automatic run_until_oidx(int k, int maxc);
    int n = 0;
    while (oidx != k && n < maxc) begin
      cycle();
      n++;
    end
    chk("reach_row", 64'(oidx), 64'(k));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      sq[i].delete();
      eq[i].delete();
      popped[i] = 0;
      blk[i] = 0;
    end
    tag_q.delete();
    oidx = 0;
    waiting = 0;
    done_cnt = 0;
    gap_req = -1;
    gap_left = 0;
    last_row = '0;
    last_tag = 0;
  endtask

`ifdef RLE_SEQ_PERF_EN
  task automatic chk_perf(int stalls);
    for (int i = 0; i < NR; i++)
      chk("perf_blk", 64'(bus.perf_blk_cnt[i*PERF_W +: PERF_W]),
          64'(blk[i]));
    chk("perf_stall", 64'(bus.perf_stall_cnt), 64'(stalls));
  endtask
`endif

  initial begin
    bus.cfg_enable = 1'b1;
    bus.rle_ready  = 1'b1;
    bus.rle_done   = 1'b0;
    bus.req_valid  = '0;
    bus.req_row    = '0;
    for (int i = 0; i < NR; i++) begin
      popped[i] = 0;
      blk[i] = 0;
    end
    do_reset();
    do_reset();

    // single block with the reference rows
    done_dly = 5;
    push_row(0, 64'h4201_0000_0000_0000);
    push_row(0, 64'h0000_0000_0000_0C00);
    for (int k = 0; k < 6; k++) push_row(0, '0);
    tag_q.push_back(0);
    cycle();
    chk("grant_ready", 64'(bus.req_ready), 64'(3'b001));
    chk("grant_busy",  64'(bus.busy),      64'(1));
    chk("grant_norow", 64'(bus.rle_row_valid), 64'(0));
    cycle();
    chk("first_row", 64'(bus.rle_row_valid), 64'(1));
    run_idle("single_drain", 100);

    // fairness from a fresh pointer
    do_reset();
    done_dly = 2;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR; r++) begin
        queue_rand(r);
        tag_q.push_back(r);
      end
    runchk = 1;
    seen_busy = 0;
    run_idle("fair_drain", 300);
    runchk = 0;

    // requester gap mid-block
    bub = 0;
    popped[1] = 0;
    gap_req = 1;
    gap_at = 4;
    gap_len = 3;
    queue_rand(1);
    tag_q.push_back(1);
    run_idle("gap_drain", 100);
    chk("gap_bubbles", 64'(bub), 64'(3));
    gap_req = -1;
`ifdef RLE_SEQ_PERF_EN
    chk_perf(3);
`endif

    // back-pressure, then enable drop mid-stream
    bus.rle_ready = 1'b0;
    queue_rand(0);
    queue_rand(0);
    tag_q.push_back(0);
    tag_q.push_back(0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("bp_busy",  64'(bus.busy),      64'(0));
      chk("bp_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.rle_ready = 1'b1;
    run_until_oidx(3, 50);
    bus.cfg_enable = 1'b0;
    run_until_left(1, 100);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("dis_busy", 64'(bus.busy), 64'(0));
    end
    bus.cfg_enable = 1'b1;
    run_idle("en_drain", 100);

    // reset mid-block
    popped[1] = 0;
    gap_req = 1;
    gap_at = 5;
    gap_len = 10;
    queue_rand(1);
    tag_q.push_back(1);
    run_until_oidx(5, 50);
    cycle();
    do_reset();
    cycle();
    chk("post_rst_busy", 64'(bus.busy), 64'(0));
    queue_rand(2);
    queue_rand(0);
    tag_q.push_back(0);
    tag_q.push_back(2);
    run_idle("rst_drain", 200);

    // stray done in IDLE and mid-STREAM
    stray = 1;
    cycle();
    cycle();
    chk("stray_idle", 64'(bus.busy), 64'(0));
    queue_rand(1);
    tag_q.push_back(1);
    run_until_oidx(5, 50);
    stray = 1;
    cycle();
    chk("stray_strm", 64'(bus.busy), 64'(1));
    run_idle("stray_drain", 100);
`ifdef RLE_SEQ_PERF_EN
    chk_perf(0);
`endif

    for (int i = 0; i < NR; i++)
      chk("leftover", 64'(eq[i].size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
